// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding,
// full-word byte-enable constant and the default data-burst bound.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arbState_e;

  localparam logic [3:0] BE_FULL = 4'b1111;

  localparam int MAX_DBURST_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory-side signals
// around the memory-port arbiter. The slave modport is the arbiter's view;
// the master modport is the surrounding core plus memory.
interface mem_port_arbiter_if;

  logic        ireq;
  logic [31:0] iaddr;
  logic        idone;
  logic [31:0] irdata;

  logic        dreq;
  logic        dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        ddone;
  logic [31:0] drdata;

  logic        stall_f;
  logic        stall_m;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  ireq, iaddr, dreq, dwe, dbe, daddr, dwdata, mem_ack, mem_rdata,
    output idone, irdata, ddone, drdata, stall_f, stall_m,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output ireq, iaddr, dreq, dwe, dbe, daddr, dwdata, mem_ack, mem_rdata,
    input  idone, irdata, ddone, drdata, stall_f, stall_m,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one handshaked memory port between instruction fetch and the
// MEM-stage load/store unit. Data has priority; a burst counter forces a
// fetch grant after MAX_DBURST consecutive data grants while fetch waits.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MAX_DBURST = MAX_DBURST_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(MAX_DBURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DBURST);

  arbState_e        state_r;
  logic             memReq_r;
  logic [CNT_W-1:0] burstCnt_r;

  logic             dataWins_s;
  logic             memWe_s;
  logic [3:0]       memBe_s;
  logic [31:0]      memAddr_s;
  logic [31:0]      memWdata_s;
  logic             iDone_s;
  logic             dDone_s;
  logic [31:0]      iRdata_s;
  logic [31:0]      dRdata_s;

  // Data wins arbitration unless fetch is waiting and the burst budget is spent.
  always_comb begin
    dataWins_s = 1'b0;
    if (bus.dreq && (!bus.ireq || (burstCnt_r < MAX_CNT))) begin
      dataWins_s = 1'b1;
    end else begin
      dataWins_s = 1'b0;
    end
  end

  // Grant FSM with registered mem_req and the fetch-starvation burst counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      memReq_r   <= 1'b0;
      burstCnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dataWins_s) begin
            state_r  <= ST_GNT_D;
            memReq_r <= 1'b1;
            if (!bus.ireq) begin
              burstCnt_r <= '0;
            end else if (burstCnt_r < MAX_CNT) begin
              burstCnt_r <= burstCnt_r + CNT_W'(1);
            end else begin
              burstCnt_r <= burstCnt_r;
            end
          end else if (bus.ireq) begin
            state_r    <= ST_GNT_I;
            memReq_r   <= 1'b1;
            burstCnt_r <= '0;
          end else begin
            state_r    <= ST_IDLE;
            memReq_r   <= 1'b0;
            burstCnt_r <= '0;
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (bus.mem_ack) begin
            state_r  <= ST_IDLE;
            memReq_r <= 1'b0;
          end else begin
            state_r  <= state_r;
            memReq_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          memReq_r   <= 1'b0;
          burstCnt_r <= '0;
        end
      endcase
    end
  end

  // Memory-side request mux: granted requester's fields, all zero in IDLE.
  always_comb begin
    memWe_s    = 1'b0;
    memBe_s    = 4'b0000;
    memAddr_s  = 32'h0000_0000;
    memWdata_s = 32'h0000_0000;
    case (state_r)
      ST_GNT_I: begin
        memWe_s    = 1'b0;
        memBe_s    = BE_FULL;
        memAddr_s  = bus.iaddr;
        memWdata_s = 32'h0000_0000;
      end
      ST_GNT_D: begin
        memWe_s    = bus.dwe;
        memBe_s    = bus.dbe;
        memAddr_s  = bus.daddr;
        memWdata_s = bus.dwdata;
      end
      default: begin
        memWe_s    = 1'b0;
        memBe_s    = 4'b0000;
        memAddr_s  = 32'h0000_0000;
        memWdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Completion pulses and read-data return; an ack seen in IDLE is ignored.
  always_comb begin
    iDone_s  = (state_r == ST_GNT_I) && bus.mem_ack;
    dDone_s  = (state_r == ST_GNT_D) && bus.mem_ack;
    iRdata_s = 32'h0000_0000;
    dRdata_s = 32'h0000_0000;
    if (iDone_s) begin
      iRdata_s = bus.mem_rdata;
    end else begin
      iRdata_s = 32'h0000_0000;
    end
    if (dDone_s && !bus.dwe) begin
      dRdata_s = bus.mem_rdata;
    end else begin
      dRdata_s = 32'h0000_0000;
    end
  end

  assign bus.mem_req   = memReq_r;
  assign bus.mem_we    = memWe_s;
  assign bus.mem_be    = memBe_s;
  assign bus.mem_addr  = memAddr_s;
  assign bus.mem_wdata = memWdata_s;
  assign bus.idone     = iDone_s;
  assign bus.ddone     = dDone_s;
  assign bus.irdata    = iRdata_s;
  assign bus.drdata    = dRdata_s;
  assign bus.stall_f   = bus.ireq & ~iDone_s;
  assign bus.stall_m   = bus.dreq & ~dDone_s;

endmodule
